// File: rtl/cm0_wic_pkg.sv
// Shared definitions for the Cortex-M0 wake-up interrupt controller.
// State encoding and the fixed meaning of the low wake-line indices.
package cm0_wic_pkg;

   typedef enum logic [1:0] {
      WIC_IDLE  = 2'b00,
      WIC_ARMED = 2'b01,
      WIC_WAKE  = 2'b10
   } wic_state_e;

   localparam int WIC_NMI      = 0;
   localparam int WIC_RXEV     = 1;
   localparam int WIC_IRQ_BASE = 2;

endpackage

// File: rtl/cm0_wic_sync.sv
// Per-bit multi-flop synchroniser for the asynchronous wake lines.
// chain[0] captures the raw input; chain[STAGES-1] is the synchronised output.
module cm0_wic_sync #(
   parameter int WIDTH  = 34,
   parameter int STAGES = 2
) (
   input  logic             hclk,
   input  logic             hreset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] chain;

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) chain <= '0;
      else           chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/cm0_wic_ctrl.sv
// Wake-up interrupt controller: mask register, pending capture and the
// PMU arm/wake handshake. Outputs decode straight from the state register.
module cm0_wic_ctrl
   import cm0_wic_pkg::*;
#(
   parameter int WICLINES    = 34,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE        = 0
) (
   input  logic                hclk,
   input  logic                hreset_n,
   input  logic                wic_load_i,
   input  logic                wic_clear_i,
   input  logic [WICLINES-1:0] wic_mask_i,
   input  logic [WICLINES-1:0] int_i,
   input  logic                wic_en_req_i,
   output logic                wic_en_ack_o,
   output logic                wakeup_o,
   output logic [WICLINES-1:0] pend_o,
   input  logic [WICLINES-1:0] pend_clr_i,
   output logic [WICLINES-1:0] mask_o
);

   wic_state_e          state, state_nxt;
   logic [WICLINES-1:0] sync_q, prev, mask, pend, det, set;
   logic                active;

   cm0_wic_sync #(.WIDTH(WICLINES), .STAGES(SYNC_STAGES)) u_sync (
      .hclk     (hclk),
      .hreset_n (hreset_n),
      .d        (int_i),
      .q        (sync_q)
   );

   assign active = (state != WIC_IDLE);
   assign det    = (EDGE != 0) ? (sync_q & ~prev) : sync_q;
   assign set    = active ? (mask & det) : '0;

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state <= WIC_IDLE;
         prev  <= '0;
         mask  <= '0;
         pend  <= '0;
      end else begin
         state <= state_nxt;
         prev  <= sync_q;
         // Mask is frozen once armed; clear beats load.
         if (!active && wic_clear_i)  mask <= '0;
         else if (!active && wic_load_i) mask <= wic_mask_i;
         if (!active && wic_clear_i)  pend <= '0;
         else                         pend <= (pend & ~pend_clr_i) | set;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WIC_IDLE:  if (wic_en_req_i && (mask != '0)) state_nxt = WIC_ARMED;
         WIC_ARMED: begin
            if (!wic_en_req_i)              state_nxt = WIC_IDLE;
            else if ((pend | set) != '0)    state_nxt = WIC_WAKE;
         end
         WIC_WAKE:  if (!wic_en_req_i) state_nxt = WIC_IDLE;
         default:   state_nxt = WIC_IDLE;
      endcase
   end

   assign wic_en_ack_o = (state == WIC_ARMED) || (state == WIC_WAKE);
   assign wakeup_o     = (state == WIC_WAKE);
   assign pend_o       = pend;
   assign mask_o       = mask;

endmodule
